// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage_if
// Purpose  : Bundles the decoded ID fields, the EX/MEM and MEM/WB bypass
//            buses and the EX-side results of ex_operand_stage.
//            master = pipeline side that drives ID/bypass, slave = the stage.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_operand_stage_if #(
  parameter int B_DAT     = 32,
  parameter int B_ALUCTRL = 4,
  parameter int B_REG     = 5
);

  // ID-stage decoded instruction
  logic                 id_valid;
  logic [B_DAT-1:0]     id_rs_dat;
  logic [B_DAT-1:0]     id_rt_dat;
  logic [B_DAT-1:0]     id_imm;
  logic [4:0]           id_shamt;
  logic [B_REG-1:0]     id_rs;
  logic [B_REG-1:0]     id_rt;
  logic [B_REG-1:0]     id_rd;
  logic                 id_use_rs;
  logic                 id_use_rt;
  logic                 id_a_sel;
  logic [1:0]           id_b_sel;
  logic [B_ALUCTRL-1:0] id_aluctrl;
  logic                 id_regwrite;
  logic                 id_memread;
  logic                 id_memwrite;

  // Pipeline control
  logic                 flush;
  logic                 hold;

  // Bypass buses from downstream stages
  logic                 exmem_regwrite;
  logic [B_REG-1:0]     exmem_rd;
  logic [B_DAT-1:0]     exmem_result;
  logic                 memwb_regwrite;
  logic [B_REG-1:0]     memwb_rd;
  logic [B_DAT-1:0]     memwb_result;

  // EX-stage outputs
  logic [B_DAT-1:0]     alu_a;
  logic [B_DAT-1:0]     alu_b;
  logic [B_ALUCTRL-1:0] alu_ctrl;
  logic                 ex_valid;
  logic                 ex_regwrite;
  logic                 ex_memread;
  logic                 ex_memwrite;
  logic [B_REG-1:0]     ex_rd;
  logic [B_DAT-1:0]     ex_store_dat;
  logic                 stall;

  modport master (
    output id_valid, id_rs_dat, id_rt_dat, id_imm, id_shamt,
           id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_a_sel, id_b_sel, id_aluctrl,
           id_regwrite, id_memread, id_memwrite,
           flush, hold,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_ctrl,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite,
           ex_rd, ex_store_dat, stall
  );

  modport slave (
    input  id_valid, id_rs_dat, id_rt_dat, id_imm, id_shamt,
           id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
           id_a_sel, id_b_sel, id_aluctrl,
           id_regwrite, id_memread, id_memwrite,
           flush, hold,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_ctrl,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite,
           ex_rd, ex_store_dat, stall
  );

endinterface
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX pipeline register with operand selection for the ALU,
//            hazard detection and stall request towards IF/ID.
//            Optional macro EX_FWD_EN: when defined, EX/MEM and MEM/WB results
//            are bypassed onto the operands and only load-use hazards stall.
//            When undefined, operands come from the registered register-file
//            data and any RAW hazard against EX or EX/MEM stalls instead.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
  parameter int B_DAT     = 32,
  parameter int B_ALUCTRL = 4,
  parameter int B_REG     = 5
) (
  input  logic              clk,
  input  logic              reset,
  ex_operand_stage_if.slave bus
);

  // b-operand select encodings (value 3 is reserved and falls back to rt)
  localparam logic [1:0] c_bsel_imm   = 2'd1;
  localparam logic [1:0] c_bsel_shamt = 2'd2;

  // --------------------------------------------------------------------------
  // ID/EX pipeline registers
  // --------------------------------------------------------------------------
  logic                 r_valid;
  logic                 r_regwrite;
  logic                 r_memread;
  logic                 r_memwrite;
  logic [B_REG-1:0]     r_rd;
  logic [B_DAT-1:0]     r_rs_dat;
  logic [B_DAT-1:0]     r_rt_dat;
  logic [B_DAT-1:0]     r_imm;
  logic [4:0]           r_shamt;
  logic                 r_a_sel;
  logic [1:0]           r_b_sel;
  logic [B_ALUCTRL-1:0] r_aluctrl;
`ifdef EX_FWD_EN
  logic [B_REG-1:0]     r_rs;
  logic [B_REG-1:0]     r_rt;
`endif

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic             w_ex_hit;       // a used ID source names the EX destination
  logic             w_load_use;     // load in EX feeds the ID instruction
  logic             w_hazard;       // raw hazard before the flush gate
  logic             w_stall;
  logic [B_DAT-1:0] w_fwd_rs;
  logic [B_DAT-1:0] w_fwd_rt;

  assign w_ex_hit   = (bus.id_use_rs && (bus.id_rs == r_rd)) ||
                      (bus.id_use_rt && (bus.id_rt == r_rd));

  assign w_load_use = bus.id_valid && r_valid && r_memread &&
                      (r_rd != '0) && w_ex_hit;

`ifdef EX_FWD_EN
  // With bypassing only a load result is too late for the next instruction.
  assign w_hazard = w_load_use;
`else
  logic w_alu_use;   // any register writer in EX feeds the ID instruction
  logic w_mem_use;   // the EX/MEM writer feeds the ID instruction
  logic w_unused_bypass;

  assign w_alu_use = bus.id_valid && r_valid && r_regwrite &&
                     (r_rd != '0) && w_ex_hit;

  assign w_mem_use = bus.id_valid && bus.exmem_regwrite &&
                     (bus.exmem_rd != '0) &&
                     ((bus.id_use_rs && (bus.id_rs == bus.exmem_rd)) ||
                      (bus.id_use_rt && (bus.id_rt == bus.exmem_rd)));

  // MEM/WB conflicts are resolved by the register file writing before read,
  // so the bypass data buses are not consumed in this build.
  assign w_unused_bypass = ^{bus.exmem_result, bus.memwb_regwrite,
                             bus.memwb_rd, bus.memwb_result};

  assign w_hazard = w_load_use || w_alu_use || w_mem_use;
`endif

  // A flushed ID instruction is discarded anyway, so it must not stall.
  assign w_stall   = w_hazard && !bus.flush;
  assign bus.stall = w_stall;

  // --------------------------------------------------------------------------
  // Pipeline register update: reset > hold > flush/stall bubble > load
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || (!bus.hold && (bus.flush || w_stall))) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_rd       <= '0;
      r_rs_dat   <= '0;
      r_rt_dat   <= '0;
      r_imm      <= '0;
      r_shamt    <= '0;
      r_a_sel    <= 1'b0;
      r_b_sel    <= '0;
      r_aluctrl  <= '0;
`ifdef EX_FWD_EN
      r_rs       <= '0;
      r_rt       <= '0;
`endif
    end else if (!bus.hold) begin
      r_valid    <= bus.id_valid;
      r_regwrite <= bus.id_regwrite && bus.id_valid;
      r_memread  <= bus.id_memread  && bus.id_valid;
      r_memwrite <= bus.id_memwrite && bus.id_valid;
      r_rd       <= bus.id_rd;
      r_rs_dat   <= bus.id_rs_dat;
      r_rt_dat   <= bus.id_rt_dat;
      r_imm      <= bus.id_imm;
      r_shamt    <= bus.id_shamt;
      r_a_sel    <= bus.id_a_sel;
      r_b_sel    <= bus.id_b_sel;
      r_aluctrl  <= bus.id_aluctrl;
`ifdef EX_FWD_EN
      r_rs       <= bus.id_rs;
      r_rt       <= bus.id_rt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Operand resolution: youngest producer (EX/MEM) wins, r0 never bypassed
  // --------------------------------------------------------------------------
  always_comb begin
    w_fwd_rs = r_rs_dat;
    w_fwd_rt = r_rt_dat;
`ifdef EX_FWD_EN
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs)) begin
      w_fwd_rs = bus.exmem_result;
    end else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs)) begin
      w_fwd_rs = bus.memwb_result;
    end
    if (bus.exmem_regwrite && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rt)) begin
      w_fwd_rt = bus.exmem_result;
    end else if (bus.memwb_regwrite && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rt)) begin
      w_fwd_rt = bus.memwb_result;
    end
`endif
  end

  // ALU b-operand select: rt, immediate or zero-extended shift amount
  always_comb begin
    bus.alu_b = w_fwd_rt;
    case (r_b_sel)
      c_bsel_imm:   bus.alu_b = r_imm;
      c_bsel_shamt: bus.alu_b = {{(B_DAT-5){1'b0}}, r_shamt};
      default:      bus.alu_b = w_fwd_rt;
    endcase
  end

  // Shift-by-shamt forms put rt on the a side
  assign bus.alu_a        = r_a_sel ? w_fwd_rt : w_fwd_rs;
  assign bus.alu_ctrl     = r_aluctrl;
  assign bus.ex_store_dat = w_fwd_rt;
  assign bus.ex_valid     = r_valid;
  assign bus.ex_regwrite  = r_regwrite;
  assign bus.ex_memread   = r_memread;
  assign bus.ex_memwrite  = r_memwrite;
  assign bus.ex_rd        = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Purpose  : Directed self-checking bench for ex_operand_stage (vector table
//            plus hand-written hazard/forwarding sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

  localparam int B_DAT     = 32;
  localparam int B_ALUCTRL = 4;
  localparam int B_REG     = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.B_DAT(B_DAT), .B_ALUCTRL(B_ALUCTRL), .B_REG(B_REG)) bus ();

  ex_operand_stage #(.B_DAT(B_DAT), .B_ALUCTRL(B_ALUCTRL), .B_REG(B_REG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid;
    logic [31:0] rs_dat;
    logic [31:0] rt_dat;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic [3:0]  ctrl;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        flush;
    logic        e_valid;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_store;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_mr;
    logic        e_mw;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bypass();
    bus.exmem_regwrite = 1'b0;
    bus.exmem_rd       = '0;
    bus.exmem_result   = '0;
    bus.memwb_regwrite = 1'b0;
    bus.memwb_rd       = '0;
    bus.memwb_result   = '0;
  endtask

  task automatic set_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic use_rs, input logic use_rt,
                        input logic [31:0] rs_dat, input logic [31:0] rt_dat,
                        input logic rw, input logic mr);
    bus.id_valid    = valid;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_use_rs   = use_rs;
    bus.id_use_rt   = use_rt;
    bus.id_rs_dat   = rs_dat;
    bus.id_rt_dat   = rt_dat;
    bus.id_imm      = '0;
    bus.id_shamt    = '0;
    bus.id_a_sel    = 1'b0;
    bus.id_b_sel    = 2'd0;
    bus.id_aluctrl  = '0;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_memwrite = 1'b0;
  endtask

  initial begin
    // ---------------- stimulus table ----------------
    //          valid  rs_dat         rt_dat         imm            sh     rd     as    bs     ctl    rw    mr    mw    fl
    //          e_valid e_a           e_b            e_store        e_ctl  e_rd   rw    mr    mw
    vecs[0] = '{1'b1, 32'h11,        32'h22,        32'h33,        5'd4,  5'd3,  1'b0, 2'd0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 32'h11,        32'h22,        32'h22,        4'h2,  5'd3,  1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hAAAA,      32'h5555,      32'hFFFF_FFF0, 5'd7,  5'd9,  1'b1, 2'd1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b1, 32'h5555,      32'hFFFF_FFF0, 32'h5555,      4'h6,  5'd9,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h1,         32'h8000_0000, 32'h7,         5'd31, 5'd10, 1'b1, 2'd2, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 32'h8000_0000, 32'h1F,        32'h8000_0000, 4'h8,  5'd10, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h1234,      32'h5678,      32'h9,         5'd2,  5'd0,  1'b0, 2'd3, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b1, 32'h1234,      32'h5678,      32'h5678,      4'h1,  5'd0,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'hDEAD,      32'hBEEF,      32'h0,         5'd0,  5'd7,  1'b0, 2'd0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0,
                1'b0, 32'hDEAD,      32'hBEEF,      32'hBEEF,      4'h3,  5'd7,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h42,        32'h43,        32'h44,        5'd5,  5'd6,  1'b0, 2'd1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b0, 32'h0,         32'h0,         32'h0,         4'h0,  5'd0,  1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h0F0F_0F0F, 32'h0,         32'h100,       5'd1,  5'd31, 1'b0, 2'd1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 32'h0F0F_0F0F, 32'h100,       32'h0,         4'hF,  5'd31, 1'b1, 1'b0, 1'b0};

    // ---------------- reset ----------------
    reset    = 1'b1;
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    clear_bypass();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1111, 32'h2222, 1'b1, 1'b1);
    tick();
    tick();
    check("reset_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    check("reset_alu_a", bus.alu_a, 32'h0);
    check("reset_alu_b", bus.alu_b, 32'h0);
    check("reset_alu_ctrl", {28'b0, bus.alu_ctrl}, 32'h0);
    check("reset_stall", {31'b0, bus.stall}, 32'h0);
    reset = 1'b0;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 7; i++) begin
      set_id(vecs[i].valid, 5'd1, 5'd2, vecs[i].rd, 1'b0, 1'b0,
             vecs[i].rs_dat, vecs[i].rt_dat, vecs[i].rw, vecs[i].mr);
      bus.id_imm      = vecs[i].imm;
      bus.id_shamt    = vecs[i].shamt;
      bus.id_a_sel    = vecs[i].a_sel;
      bus.id_b_sel    = vecs[i].b_sel;
      bus.id_aluctrl  = vecs[i].ctrl;
      bus.id_memwrite = vecs[i].mw;
      bus.flush       = vecs[i].flush;
      #1;
      check($sformatf("v%0d_stall", i), {31'b0, bus.stall}, 32'h0);
      tick();
      check($sformatf("v%0d_ex_valid", i), {31'b0, bus.ex_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].e_a);
      check($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].e_b);
      check($sformatf("v%0d_store", i), bus.ex_store_dat, vecs[i].e_store);
      check($sformatf("v%0d_alu_ctrl", i), {28'b0, bus.alu_ctrl}, {28'b0, vecs[i].e_ctrl});
      check($sformatf("v%0d_ex_rd", i), {27'b0, bus.ex_rd}, {27'b0, vecs[i].e_rd});
      check($sformatf("v%0d_regwrite", i), {31'b0, bus.ex_regwrite}, {31'b0, vecs[i].e_rw});
      check($sformatf("v%0d_memread", i), {31'b0, bus.ex_memread}, {31'b0, vecs[i].e_mr});
      check($sformatf("v%0d_memwrite", i), {31'b0, bus.ex_memwrite}, {31'b0, vecs[i].e_mw});
    end
    bus.flush = 1'b0;

    // ---------------- ALU dependency: ADD r3 then SUB r4,r3,r3 ----------------
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 32'h99, 32'h99, 1'b1, 1'b0);
    #1;
`ifdef EX_FWD_EN
    check("alu_dep_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h10;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'h20;
    #1;
    check("fwd_prio_alu_a", bus.alu_a, 32'h10);
    check("fwd_prio_alu_b", bus.alu_b, 32'h10);
    check("fwd_prio_store", bus.ex_store_dat, 32'h10);
    bus.exmem_regwrite = 1'b0;
    #1;
    check("fwd_memwb_alu_a", bus.alu_a, 32'h20);
`else
    check("alu_dep_stall1", {31'b0, bus.stall}, 32'h1);
    tick();
    check("alu_dep_bubble1", {31'b0, bus.ex_valid}, 32'h0);
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h10;
    #1;
    check("alu_dep_stall2", {31'b0, bus.stall}, 32'h1);
    tick();
    check("alu_dep_bubble2", {31'b0, bus.ex_valid}, 32'h0);
    bus.exmem_regwrite = 1'b0;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'h20;
    bus.id_rs_dat = 32'h77; bus.id_rt_dat = 32'h77;
    #1;
    check("alu_dep_stall3", {31'b0, bus.stall}, 32'h0);
    tick();
    check("nofwd_alu_a", bus.alu_a, 32'h77);
    check("nofwd_alu_b", bus.alu_b, 32'h77);
    check("nofwd_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
`endif
    clear_bypass();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    // ---------------- load-use: LW r5 then consumer of r5 ----------------
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'h1111, 32'h0, 1'b1, 1'b0);
    #1;
    check("loaduse_stall", {31'b0, bus.stall}, 32'h1);
    tick();
    check("loaduse_bubble", {31'b0, bus.ex_valid}, 32'h0);
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h1234;
    #1;
`ifdef EX_FWD_EN
    check("loaduse_single_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    bus.exmem_regwrite = 1'b0;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'hCAFE;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
`else
    check("loaduse_exmem_stall", {31'b0, bus.stall}, 32'h1);
    tick();
    bus.exmem_regwrite = 1'b0;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'hBAD0;
    bus.id_rs_dat = 32'hCAFE;
    #1;
    check("loaduse_release", {31'b0, bus.stall}, 32'h0);
    tick();
`endif
    check("loaduse_alu_a", bus.alu_a, 32'hCAFE);
    check("loaduse_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
    clear_bypass();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    // ---------------- r0 is never forwarded ----------------
    bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hFFFF;
    bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hEEEE;
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("r0_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    check("r0_alu_a", bus.alu_a, 32'h0);
    check("r0_store", bus.ex_store_dat, 32'h0);
    clear_bypass();

    // ---------------- flush beats load-use, hold beats flush ----------------
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 32'h55, 32'h0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 32'h66, 32'h0, 1'b1, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    check("flush_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
    check("flush_ex_rd", {27'b0, bus.ex_rd}, 32'h0);
    check("flush_regwrite", {31'b0, bus.ex_regwrite}, 32'h0);
    bus.flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 32'hABCD, 32'h1234, 1'b1, 1'b0);
    tick();
    check("pre_hold_ex_rd", {27'b0, bus.ex_rd}, 32'd11);
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 5'd12, 1'b0, 1'b0, 32'h1, 32'h2, 1'b0, 1'b1);
    tick();
    check("hold_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
    check("hold_ex_rd", {27'b0, bus.ex_rd}, 32'd11);
    check("hold_alu_a", bus.alu_a, 32'hABCD);
    check("hold_memread", {31'b0, bus.ex_memread}, 32'h0);
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding and load-use hazard detection.
- Sits directly upstream of the alu block and drives its a, b and ALUCtrl inputs.
- Also issues the stall request to the IF/ID stages.
- Registers decoded fields each cycle; forwarding muxes resolve final ALU operands combinationally from the registered values and the EX/MEM and MEM/WB bypass buses.

Parameters:
B_DAT, 32, datapath width; matches BUS_DAT.
B_ALUCTRL, 4, ALU control width; matches BUS_ALUCtrl.
B_REG, 5, register index width.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_dat, id_rt_dat  in  B_DAT  register file read data
id_imm  in  B_DAT  sign/zero-extended immediate
id_shamt  in  5  shift amount field
id_rs, id_rt, id_rd  in  B_REG  source and destination indices
id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
id_a_sel  in  1  0 = rs, 1 = rt onto ALU a (shift-by-shamt forms)
id_b_sel  in  2  0 = rt, 1 = imm, 2 = {27'b0, shamt}; 3 reserved, treated as 0
id_aluctrl  in  B_ALUCTRL  ALU operation code
id_regwrite, id_memread, id_memwrite  in  1  control flags
flush  in  1  branch/jump redirect; kill instruction entering EX
hold  in  1  global freeze (memory wait)
exmem_regwrite  in  1  EX/MEM writes a register
exmem_rd  in  B_REG  EX/MEM destination
exmem_result  in  B_DAT  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB writes a register
memwb_rd  in  B_REG  MEM/WB destination
memwb_result  in  B_DAT  MEM/WB writeback data
alu_a, alu_b  out  B_DAT  operands to alu
alu_ctrl  out  B_ALUCTRL  operation to alu
ex_valid, ex_regwrite, ex_memread, ex_memwrite  out  1  registered control (killed if !ex_valid)
ex_rd  out  B_REG  registered destination
ex_store_dat  out  B_DAT  forwarded rt value for stores
stall  out  1  load-use hazard; IF/ID must hold

Behaviour:
- Register update priority each edge: reset > hold > flush > stall > load.
- reset: ex_valid, ex_regwrite, ex_memread, ex_memwrite = 0; ex_rd = 0; all data regs = 0; alu_ctrl = 0 (ADD). Outputs therefore read 0.
- hold: all registers keep their value. stall is still computed but has no effect.
- flush or stall (no hold): bubble loaded. ex_valid and all control flags = 0, ex_rd = 0; data regs don't-care (implementation clears them).
- Otherwise: all id_* fields loaded; ex_valid = id_valid; control flags ANDed with id_valid.
- stall is combinational: id_valid & ex_valid & ex_memread & ex_rd != 0 & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
- stall is gated off by flush: the younger instruction dies anyway.
- A stall lasts exactly 1 cycle per load. The next cycle the load is in MEM and the bypass is from MEM/WB.
- Forwarding (combinational, per source rs/rt):
  - EX/MEM match (exmem_regwrite & exmem_rd != 0 & exmem_rd == idx) has priority.
  - Next is MEM/WB match under the same rules.
  - Otherwise the registered file data is used.
  - Register 0 is never forwarded.
- alu_a = id_a_sel-selected forwarded value.
- alu_b mux per b_sel: forwarded rt, imm, or shamt zero-extended.
- ex_store_dat = forwarded rt.
- Latency: ID fields appear on alu_* one cycle after load.

Optional Feature:
- Macro EX_FWD_EN.
- Defined: forwarding as above.
- Undefined: no bypass; operands come straight from the registered file data. stall is then also asserted on a used-source match with any valid ex_regwrite ex_rd, or with exmem_regwrite exmem_rd (nonzero). MEM/WB conflicts are covered by the register file's write-before-read. Ports remain present but unused.

Test Plan:
- reset held 2 cycles with id_valid=1 -> ex_valid=0, alu_a=alu_b=0, stall=0, alu_ctrl=0.
- Back-to-back ADD r3 then SUB r4,r3,r3; exmem_rd=3 result 0x10, memwb_rd=3 result 0x20 -> alu_a=alu_b=0x10 (EX/MEM priority).
- LW r5 in EX (ex_memread=1, ex_rd=5), ID uses rs=5 -> stall=1 one cycle, next ex_valid=0; then dependent enters with memwb_rd=5 data 0xCAFE -> alu_a=0xCAFE.
- exmem_regwrite=1, exmem_rd=0, result 0xFFFF; ID reads r0 with id_rs_dat=0 -> alu_a=0.
- flush=1 with a load-use condition present -> stall=0, bubble loaded; hold=1 with flush=1 -> registers unchanged.
- EX_FWD_EN undefined: ADD r3 in EX, ID reads r3 -> stall=1 for 2 cycles (EX then EX/MEM), operand = id_rs_dat afterwards.
